// File: rtl/passcode_comparator.sv
// Keypad passcode comparator: accepts up to DIGITS BCD key presses, either
// programming a new stored code (initialize = 1) or verifying the entry
// against the stored code (initialize = 0).
module passcode_comparator #(
  parameter int unsigned         DIGITS       = 6,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        bcd,
  input  logic              key_pressed,
  input  logic              clear,
  input  logic              initialize,
  output logic [2:0]        digit_count,
  output logic [DIGITS-1:0] cs,
  output logic [DIGITS-1:0] led,
  output logic              correct
);

  localparam int unsigned      CNT_W    = 3;
  localparam int unsigned      BCD_W    = 4;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);
  localparam logic [BCD_W-1:0] MAX_BCD  = BCD_W'(9);

  logic              r_key_q;
  logic              r_init_q;
  logic              r_mismatch;
  logic              r_correct;
  logic [CNT_W-1:0]  r_count;
  logic [DIGITS-1:0] r_led;
  logic [BCD_W-1:0]  r_digit [DIGITS];

  logic              w_strobe;
  logic              w_init_edge;
  logic              w_abort;
  logic              w_accept;
  logic              w_mismatch_next;
  logic [BCD_W-1:0]  w_stored;

  // Press strobe, initialize-edge abort and the accept qualifier
  always_comb begin
    w_strobe    = key_pressed & ~r_key_q;
    w_init_edge = initialize ^ r_init_q;
    w_abort     = clear | w_init_edge;
    w_accept    = w_strobe & ~w_abort & ~reset & (bcd <= MAX_BCD) &
                  (r_count < FULL_CNT);
  end

  // Select the stored digit for the slot about to be entered
  always_comb begin
    w_stored = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_count == CNT_W'(i)) begin
        w_stored = r_digit[i];
      end
    end
    w_mismatch_next = r_mismatch | (bcd != w_stored);
  end

  // One-hot slot select, live only in the cycle of an accepted press
  always_comb begin
    cs = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      cs[i] = w_accept & (r_count == CNT_W'(i));
    end
  end

  // Entry state: edge-detect copies, counter, thermometer, match flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_q    <= 1'b0;
      r_init_q   <= 1'b0;
      r_count    <= '0;
      r_led      <= '0;
      r_mismatch <= 1'b0;
      r_correct  <= 1'b0;
    end else begin
      r_key_q  <= key_pressed;
      r_init_q <= initialize;
      if (w_abort) begin
        r_count    <= '0;
        r_led      <= '0;
        r_mismatch <= 1'b0;
        r_correct  <= 1'b0;
      end else if (w_accept) begin
        r_count <= r_count + CNT_W'(1);
        r_led   <= {r_led[DIGITS-2:0], 1'b1};
        if (initialize) begin
          r_correct <= 1'b0;
        end else begin
          r_mismatch <= w_mismatch_next;
          // The final digit's own comparison decides the result
          if (r_count == LAST_CNT && !w_mismatch_next) begin
            r_correct <= 1'b1;
          end
        end
      end
    end
  end

  // Stored code: reloaded on reset, rewritten slot by slot in initialize mode
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        r_digit[i] <= DEFAULT_CODE[i*BCD_W +: BCD_W];
      end
    end else if (w_accept && initialize) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (r_count == CNT_W'(i)) begin
          r_digit[i] <= bcd;
        end
      end
    end
  end

  assign digit_count = r_count;
  assign led         = r_led;
  assign correct     = r_correct;

endmodule

// File: tb/tb_passcode_comparator.sv
// Bench for passcode_comparator: table of per-cycle vectors plus hand-written
// multi-cycle sequences; registered outputs are checked through a queue.
module tb_passcode_comparator;

  logic       clk;
  logic       reset;
  logic [3:0] bcd;
  logic       key_pressed;
  logic       clear;
  logic       initialize;
  logic [2:0] digit_count;
  logic [5:0] cs;
  logic [5:0] led;
  logic       correct;

  passcode_comparator #(
    .DIGITS       (6),
    .DEFAULT_CODE (24'h000000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bcd         (bcd),
    .key_pressed (key_pressed),
    .clear       (clear),
    .initialize  (initialize),
    .digit_count (digit_count),
    .cs          (cs),
    .led         (led),
    .correct     (correct)
  );

  typedef struct {
    logic       rst;
    logic       key;
    logic       clr;
    logic       init;
    logic [3:0] bcd;
    logic [5:0] e_cs;
    logic [2:0] e_cnt;
    logic       e_cor;
  } vec_t;

  typedef struct {
    int         id;
    logic [2:0] cnt;
    logic [5:0] led;
    logic       cor;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] therm(input logic [2:0] n);
    logic [5:0] t;
    t = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < int'(n)) t[i] = 1'b1;
    end
    return t;
  endfunction

  function automatic vec_t mk(input logic rst, input logic key, input logic clr,
                              input logic init, input logic [3:0] b,
                              input logic [5:0] ecs, input logic [2:0] ecnt,
                              input logic ecor);
    vec_t v;
    v.rst = rst; v.key = key; v.clr = clr; v.init = init; v.bcd = b;
    v.e_cs = ecs; v.e_cnt = ecnt; v.e_cor = ecor;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, id, act, exp);
    end
  endtask

  // Drive one cycle at negedge, check cs before the edge, queue the rest
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset       = v.rst;
    key_pressed = v.key;
    clear       = v.clr;
    initialize  = v.init;
    bcd         = v.bcd;
    #1;
    chk("cs", vec_id, 32'(cs), 32'(v.e_cs));
    e.id  = vec_id;
    e.cnt = v.e_cnt;
    e.led = therm(v.e_cnt);
    e.cor = v.e_cor;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Scoreboard: compare registered outputs just after each rising edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("digit_count", e.id, 32'(digit_count), 32'(e.cnt));
      chk("led", e.id, 32'(led), 32'(e.led));
      chk("correct", e.id, 32'(correct), 32'(e.cor));
    end
  end

  task automatic add(input logic rst, input logic key, input logic clr,
                     input logic init, input logic [3:0] b, input logic [5:0] ecs,
                     input logic [2:0] ecnt, input logic ecor);
    tbl.push_back(mk(rst, key, clr, init, b, ecs, ecnt, ecor));
  endtask

  task automatic add_press(input logic init, input logic [3:0] b,
                           input logic [5:0] ecs, input logic [2:0] ecnt,
                           input logic ecor);
    add(1'b0, 1'b1, 1'b0, init, b, ecs, ecnt, ecor);
    add(1'b0, 1'b0, 1'b0, init, b, 6'b0, ecnt, ecor);
  endtask

  task automatic cyc(input logic rst, input logic key, input logic clr,
                     input logic init, input logic [3:0] b, input logic [5:0] ecs,
                     input logic [2:0] ecnt, input logic ecor);
    apply(mk(rst, key, clr, init, b, ecs, ecnt, ecor));
  endtask

  task automatic prd(input logic init, input logic [3:0] b,
                     input logic [5:0] ecs, input logic [2:0] ecnt,
                     input logic ecor);
    cyc(1'b0, 1'b1, 1'b0, init, b, ecs, ecnt, ecor);
    cyc(1'b0, 1'b0, 1'b0, init, b, 6'b0, ecnt, ecor);
  endtask

  initial begin
    reset       = 1'b1;
    key_pressed = 1'b0;
    clear       = 1'b0;
    initialize  = 1'b0;
    bcd         = 4'd0;

    // Reset, then six zeros against the default code
    add(1, 0, 0, 0, 4'd0, 6'b0, 3'd0, 0);
    add(1, 0, 0, 0, 4'd0, 6'b0, 3'd0, 0);
    add_press(0, 4'd0, 6'b000001, 3'd1, 0);
    add_press(0, 4'd0, 6'b000010, 3'd2, 0);
    add_press(0, 4'd0, 6'b000100, 3'd3, 0);
    add_press(0, 4'd0, 6'b001000, 3'd4, 0);
    add_press(0, 4'd0, 6'b010000, 3'd5, 0);
    add_press(0, 4'd0, 6'b100000, 3'd6, 1);
    // Seventh press and an invalid digit are ignored
    add_press(0, 4'd0, 6'b0, 3'd6, 1);
    add_press(0, 4'hA, 6'b0, 3'd6, 1);
    // Clear, then enter initialize mode (edge aborts) and program 123456
    add(0, 0, 1, 0, 4'd0, 6'b0, 3'd0, 0);
    add(0, 0, 0, 1, 4'd0, 6'b0, 3'd0, 0);
    add_press(1, 4'd1, 6'b000001, 3'd1, 0);
    add_press(1, 4'd2, 6'b000010, 3'd2, 0);
    add_press(1, 4'd3, 6'b000100, 3'd3, 0);
    add_press(1, 4'd4, 6'b001000, 3'd4, 0);
    add_press(1, 4'd5, 6'b010000, 3'd5, 0);
    add_press(1, 4'd6, 6'b100000, 3'd6, 0);
    add_press(1, 4'd7, 6'b0, 3'd6, 0);
    // Leave initialize mode and verify 123456
    add(0, 0, 0, 0, 4'd0, 6'b0, 3'd0, 0);
    add_press(0, 4'd1, 6'b000001, 3'd1, 0);
    add_press(0, 4'd2, 6'b000010, 3'd2, 0);
    add_press(0, 4'd3, 6'b000100, 3'd3, 0);
    add_press(0, 4'd4, 6'b001000, 3'd4, 0);
    add_press(0, 4'd5, 6'b010000, 3'd5, 0);
    add_press(0, 4'd6, 6'b100000, 3'd6, 1);
    // Wrong last digit: full count but no match
    add(0, 0, 1, 0, 4'd0, 6'b0, 3'd0, 0);
    add_press(0, 4'd1, 6'b000001, 3'd1, 0);
    add_press(0, 4'd2, 6'b000010, 3'd2, 0);
    add_press(0, 4'd3, 6'b000100, 3'd3, 0);
    add_press(0, 4'd4, 6'b001000, 3'd4, 0);
    add_press(0, 4'd5, 6'b010000, 3'd5, 0);
    add_press(0, 4'd7, 6'b100000, 3'd6, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Key held for ten cycles counts as one press
    cyc(0, 0, 1, 0, 4'd0, 6'b0, 3'd0, 0);
    cyc(0, 1, 0, 0, 4'd3, 6'b000001, 3'd1, 0);
    repeat (9) cyc(0, 1, 0, 0, 4'd3, 6'b0, 3'd1, 0);
    cyc(0, 0, 0, 0, 4'd3, 6'b0, 3'd1, 0);

    // Clear wins over a simultaneous press; stored code untouched
    cyc(0, 0, 1, 0, 4'd0, 6'b0, 3'd0, 0);
    prd(0, 4'd1, 6'b000001, 3'd1, 0);
    prd(0, 4'd2, 6'b000010, 3'd2, 0);
    prd(0, 4'd3, 6'b000100, 3'd3, 0);
    cyc(0, 1, 1, 0, 4'd4, 6'b0, 3'd0, 0);
    cyc(0, 0, 0, 0, 4'd0, 6'b0, 3'd0, 0);
    prd(0, 4'd1, 6'b000001, 3'd1, 0);
    prd(0, 4'd2, 6'b000010, 3'd2, 0);
    prd(0, 4'd3, 6'b000100, 3'd3, 0);
    prd(0, 4'd4, 6'b001000, 3'd4, 0);
    prd(0, 4'd5, 6'b010000, 3'd5, 0);
    prd(0, 4'd6, 6'b100000, 3'd6, 1);

    // Partial reprogram: new 98 in slots 0-1, old 3456 kept
    cyc(0, 0, 0, 1, 4'd0, 6'b0, 3'd0, 0);
    prd(1, 4'd9, 6'b000001, 3'd1, 0);
    prd(1, 4'd8, 6'b000010, 3'd2, 0);
    cyc(0, 0, 0, 0, 4'd0, 6'b0, 3'd0, 0);
    prd(0, 4'd9, 6'b000001, 3'd1, 0);
    prd(0, 4'hF, 6'b0, 3'd1, 0);
    prd(0, 4'd8, 6'b000010, 3'd2, 0);
    prd(0, 4'd3, 6'b000100, 3'd3, 0);
    prd(0, 4'd4, 6'b001000, 3'd4, 0);
    prd(0, 4'd5, 6'b010000, 3'd5, 0);
    prd(0, 4'd6, 6'b100000, 3'd6, 1);

    // Reset while correct, with a coincident press; code reverts to default
    cyc(1, 1, 0, 0, 4'd9, 6'b0, 3'd0, 0);
    cyc(0, 0, 0, 0, 4'd0, 6'b0, 3'd0, 0);
    prd(0, 4'd0, 6'b000001, 3'd1, 0);
    prd(0, 4'd0, 6'b000010, 3'd2, 0);
    prd(0, 4'd0, 6'b000100, 3'd3, 0);
    prd(0, 4'd0, 6'b001000, 3'd4, 0);
    prd(0, 4'd0, 6'b010000, 3'd5, 0);
    prd(0, 4'd0, 6'b100000, 3'd6, 1);

    repeat (2) @(negedge clk);
    chk("drain", -1, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
